// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl
// Cycle-detection controller that sits in front of the per-node state registers
// of a gene-regulatory-network accelerator. It loads every node with an initial
// state. It then runs a Floyd tortoise/hare search: the s0 copy steps every other
// step and the s1 copy steps every step. When the copies meet, s0 is frozen and
// s1 keeps stepping until it comes back to s0, which measures the attractor period.
//
// Optional build macro: GNR_ATTR_SNAPSHOT_EN
//   defined   : attractor_state captures state_s0 at the meet
//   undefined : attractor_state is tied to 0
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            one-cycle request, accepted only in IDLE
//   init_vec         initial network state, captured when start is accepted
//   reset_nos        node reload strobe (one cycle, in LOAD)
//   init_state       reload value for the nodes, valid with reset_nos
//   start_s0         tortoise step enable
//   start_s1         hare step enable
//   state_s0/_s1     node state vectors read back from the nodes
//   busy             run in progress
//   done             one-cycle pulse when the result registers are valid
//   timeout          set when the step limit was reached before a result
//   meet_steps       step count at which s0 == s1 was detected
//   period           attractor period (0 on timeout)
//   attractor_state  s0 snapshot at the meet
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | reload all nodes with init_state
// FSTEP | step both copies (the node logic gates the tortoise)
// FCHK  | compare copies; the meet starts the period search
// PSTEP | step the hare only
// PCHK  | compare copies; a match gives the period
// DONE  | result valid for one cycle
module gnr_attractor_ctrl #(
  parameter int NUM_NODES = 8,
  parameter int CNT_WIDTH = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_NODES-1:0] init_vec,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  input  logic [NUM_NODES-1:0] state_s0,
  input  logic [NUM_NODES-1:0] state_s1,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] meet_steps,
  output logic [CNT_WIDTH-1:0] period,
  output logic [NUM_NODES-1:0] attractor_state
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_STEPS);
  localparam logic [CNT_WIDTH-1:0] MIN_MEET = CNT_WIDTH'(2);

  typedef enum logic [2:0] {IDLE, LOAD, FSTEP, FCHK, PSTEP, PCHK, DONE} state_t;

  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] step_cnt, period_cnt;
  logic accept, meet_hit, period_hit, limit_hit;
  logic same;

  assign same = (state_s0 == state_s1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    meet_hit   = 1'b0;
    period_hit = 1'b0;
    limit_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD:  state_nx = FSTEP;
      FSTEP: state_nx = FCHK;
      FCHK: begin
        // At step 1 both copies hold x(1), so that match says nothing.
        if ((step_cnt >= MIN_MEET) && same) begin
          meet_hit = 1'b1;
          state_nx = PSTEP;
        end else if (step_cnt == MAX_CNT) begin
          limit_hit = 1'b1;
          state_nx  = DONE;
        end else begin
          state_nx = FSTEP;
        end
      end
      PSTEP: state_nx = PCHK;
      PCHK: begin
        if (same) begin
          period_hit = 1'b1;
          state_nx   = DONE;
        end else if (step_cnt == MAX_CNT) begin
          limit_hit = 1'b1;
          state_nx  = DONE;
        end else begin
          state_nx = PSTEP;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The strobes are decoded from the next state, so that each one is registered
  // and lines up with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reset_nos  <= 1'b0;
      init_state <= '0;
      start_s0   <= 1'b0;
      start_s1   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      meet_steps <= '0;
      period     <= '0;
      step_cnt   <= '0;
      period_cnt <= '0;
    end else begin
      reset_nos  <= (state_nx == LOAD);
      start_s0   <= (state_nx == FSTEP);
      start_s1   <= (state_nx == FSTEP) || (state_nx == PSTEP);
      busy       <= (state_nx != IDLE) && (state_nx != DONE);
      done       <= (state_nx == DONE);
      // init_state also serves as the captured copy of init_vec. It is only
      // needed during LOAD, so it returns to zero afterwards.
      init_state <= accept ? init_vec : '0;
      if (accept) begin
        step_cnt   <= '0;
        period_cnt <= '0;
        meet_steps <= '0;
        period     <= '0;
        timeout    <= 1'b0;
      end
      if (state == FSTEP) step_cnt <= step_cnt + 1'b1;
      if (state == PSTEP) begin
        step_cnt   <= step_cnt + 1'b1;
        period_cnt <= period_cnt + 1'b1;
      end
      if (meet_hit)   meet_steps <= step_cnt;
      if (period_hit) period     <= period_cnt;
      if (limit_hit) begin
        timeout <= 1'b1;
        period  <= '0;
      end
    end
  end

`ifdef GNR_ATTR_SNAPSHOT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            attractor_state <= '0;
    else if (accept)    attractor_state <= '0;
    else if (meet_hit)  attractor_state <= state_s0;
    else if (limit_hit) attractor_state <= '0;
  end
`else
  assign attractor_state = '0;
`endif

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
module tb_gnr_attractor_ctrl;

`ifdef GNR_ATTR_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  start_v;
  logic [3:0]  init_vec;
  logic [1:0]  rn, ss0, ss1, busy_v, done_v, to_v;
  logic [3:0]  ist [2];
  logic [3:0]  ms0 [2];
  logic [3:0]  ms1 [2];
  logic [1:0]  ph;
  logic [15:0] meet_v [2];
  logic [15:0] per_v [2];
  logic [3:0]  snap_v [2];
  int          mode;

  int checks = 0;
  int errors = 0;
  int rn_cnt [2];
  int dn_cnt [2];
  logic [3:0] cap_init [2];

  gnr_attractor_ctrl #(.NUM_NODES(4), .CNT_WIDTH(16), .MAX_STEPS(1000)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .init_vec(init_vec),
    .reset_nos(rn[0]), .init_state(ist[0]), .start_s0(ss0[0]), .start_s1(ss1[0]),
    .state_s0(ms0[0]), .state_s1(ms1[0]), .busy(busy_v[0]), .done(done_v[0]),
    .timeout(to_v[0]), .meet_steps(meet_v[0]), .period(per_v[0]),
    .attractor_state(snap_v[0]));

  gnr_attractor_ctrl #(.NUM_NODES(4), .CNT_WIDTH(16), .MAX_STEPS(8)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .init_vec(init_vec),
    .reset_nos(rn[1]), .init_state(ist[1]), .start_s0(ss0[1]), .start_s1(ss1[1]),
    .state_s0(ms0[1]), .state_s1(ms1[1]), .busy(busy_v[1]), .done(done_v[1]),
    .timeout(to_v[1]), .meet_steps(meet_v[1]), .period(per_v[1]),
    .attractor_state(snap_v[1]));

  function automatic logic [3:0] f(input logic [3:0] x);
    case (mode)
      0: f = x;
      1: f = (x == 4'd2) ? 4'd0 : x + 4'd1;
      2: f = x + 4'd1;
      default: f = x ^ 4'b0001;
    endcase
  endfunction

  // Node model: reload on reset_nos, the hare steps on every enable, and the
  // tortoise steps on odd enables only.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rn[i]) begin
        ms0[i] <= ist[i];
        ms1[i] <= ist[i];
        ph[i]  <= 1'b1;
      end else begin
        if (ss1[i]) ms1[i] <= f(ms1[i]);
        if (ss0[i]) begin
          if (ph[i]) ms0[i] <= f(ms0[i]);
          ph[i] <= ~ph[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rn[i]) begin
        rn_cnt[i]   = rn_cnt[i] + 1;
        cap_init[i] = ist[i];
      end
      if (done_v[i]) dn_cnt[i] = dn_cnt[i] + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_out(input int s);
    all_out = 64'({rn[s], ist[s], ss0[s], ss1[s], busy_v[s], done_v[s], to_v[s],
                   meet_v[s], per_v[s], snap_v[s]});
  endfunction

  typedef struct {
    int         sel;
    int         mode;
    logic [3:0] init;
    int         meet;
    int         per;
    logic       to;
    logic [3:0] snap;
    int         lat;
    bit         noisy;
  } vec_t;

  task automatic run_case(input vec_t v);
    int  s;
    int  cnt;
    bit  seen;
    s = v.sel;
    mode = v.mode;
    init_vec = v.init;
    @(negedge clk);
    rn_cnt[s] = 0;
    dn_cnt[s] = 0;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    chk("busy_after_accept", 64'(busy_v[s]), 64'd1);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (v.noisy) start_v[s] = (cnt == 3 || cnt == 5 || cnt == 8);
      if (done_v[s]) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency", 64'(cnt), 64'(v.lat));
    chk("meet_steps", 64'(meet_v[s]), 64'(v.meet));
    chk("period", 64'(per_v[s]), 64'(v.per));
    chk("timeout", 64'(to_v[s]), 64'(v.to));
    chk("snapshot", 64'(snap_v[s]), SNAP ? 64'(v.snap) : 64'd0);
    chk("busy_at_done", 64'(busy_v[s]), 64'd0);
    // A start that arrives during DONE must be ignored.
    if (v.noisy) start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    chk("done_width", 64'(done_v[s]), 64'd0);
    chk("timeout_hold", 64'(to_v[s]), 64'(v.to));
    repeat (3) @(negedge clk);
    chk("busy_idle", 64'(busy_v[s]), 64'd0);
    chk("reset_nos_count", 64'(rn_cnt[s]), 64'd1);
    chk("done_count", 64'(dn_cnt[s]), 64'd1);
    chk("init_state_load", 64'(cap_init[s]), 64'(v.init));
    chk("meet_hold", 64'(meet_v[s]), 64'(v.meet));
  endtask

  vec_t tbl [5];

  initial begin
    int  cnt;
    bit  found;
    vec_t rv;
    start_v = 2'b00;
    init_vec = 4'd0;
    mode = 0;
    rn_cnt[0] = 0; rn_cnt[1] = 0;
    dn_cnt[0] = 0; dn_cnt[1] = 0;
    cap_init[0] = 4'd0; cap_init[1] = 4'd0;

    tbl[0] = '{sel: 0, mode: 0, init: 4'b1010, meet: 2, per: 1, to: 1'b0, snap: 4'b1010, lat: 7,  noisy: 1'b0};
    tbl[1] = '{sel: 0, mode: 1, init: 4'b0000, meet: 6, per: 3, to: 1'b0, snap: 4'b0000, lat: 19, noisy: 1'b0};
    tbl[2] = '{sel: 1, mode: 2, init: 4'b0000, meet: 0, per: 0, to: 1'b1, snap: 4'b0000, lat: 17, noisy: 1'b0};
    tbl[3] = '{sel: 0, mode: 3, init: 4'b0000, meet: 4, per: 2, to: 1'b0, snap: 4'b0000, lat: 13, noisy: 1'b1};
    tbl[4] = '{sel: 1, mode: 0, init: 4'b0101, meet: 2, per: 1, to: 1'b0, snap: 4'b0101, lat: 7,  noisy: 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outputs_dut0", all_out(0), 64'd0);
    chk("reset_outputs_dut1", all_out(1), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_case(tbl[i]);

    // Assert reset in the middle of a run, while FSTEP is active.
    mode = 1;
    init_vec = 4'b0000;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    found = 1'b0;
    cnt = 0;
    while (!found && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (ss0[0]) found = 1'b1;
    end
    chk("fstep_reached", 64'(found), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", all_out(0), 64'd0);
    @(negedge clk);
    chk("reset_held_outputs", all_out(0), 64'd0);
    rst = 1'b0;
    rv = '{sel: 0, mode: 0, init: 4'b0110, meet: 2, per: 1, to: 1'b0, snap: 4'b0110, lat: 7, noisy: 1'b0};
    run_case(rv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
